// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 sequencer: initial AddRoundKey, then NR rounds on shared datapaths; NR*(RND_LAT+1) cycles accept-to-valid.
// One block in flight: in_ready low while busy, ciphertext held in DONE until out_ready.
module aes_round_sequencer #(
  parameter int NR      = 10,
  parameter int RND_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic [127:0] dp_state,
  output logic [127:0] dp_key,
  output logic         dp_final,
  input  logic [127:0] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int            CW       = (RND_LAT < 2) ? 1 : $clog2(RND_LAT + 1);
  localparam logic [3:0]    LAST_RND = 4'(NR);
  localparam logic [CW-1:0] CAP_CNT  = CW'(RND_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  fsm_t          r_fsm;
  fsm_t          w_fsm_nxt;
  logic [127:0]  state_q;
  logic [3:0]    rnd_q;
  logic [CW-1:0] cnt_q;
  logic          w_accept;
  logic          w_capture;
  logic          w_last;

  assign w_accept  = (r_fsm == S_IDLE) && in_valid;
  assign w_capture = (r_fsm == S_RUN) && (cnt_q == CAP_CNT);
  assign w_last    = (rnd_q == LAST_RND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:  if (in_valid) w_fsm_nxt = S_RUN;
      S_RUN:   if (w_capture && w_last) w_fsm_nxt = S_DONE;
      S_DONE:  if (out_ready) w_fsm_nxt = S_IDLE;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // Key index and final-round select only track the round while running, so the key store sees 0 otherwise.
  always_comb begin
    in_ready  = (r_fsm == S_IDLE);
    out_valid = (r_fsm == S_DONE);
    busy      = (r_fsm != S_IDLE);
    rk_idx    = (r_fsm == S_RUN) ? rnd_q : 4'd0;
    dp_final  = (r_fsm == S_RUN) && w_last;
  end

  assign dp_state = state_q;
  assign dp_key   = rk_data;
  assign out_data = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      rnd_q   <= '0;
      cnt_q   <= '0;
    end else if (w_accept) begin
      state_q <= in_data ^ rk_data;
      rnd_q   <= 4'd1;
      cnt_q   <= '0;
    end else if (w_capture) begin
      state_q <= dp_result;
      cnt_q   <= '0;
      if (!w_last) rnd_q <= rnd_q + 4'd1;
    end else if (r_fsm == S_RUN) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: behavioural AES-128 round datapaths and key store around two instances (RND_LAT 2 and 3).
module tb_aes_round_sequencer;
  localparam int NR = 10;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_valid3, out_ready, out_ready3;
  logic [127:0] in_data;
  logic         in_ready, in_ready3, dp_final, dp_final3, out_valid, out_valid3, busy, busy3;
  logic [3:0]   rk_idx, rk_idx3;
  logic [127:0] rk_data, rk_data3, dp_state, dp_state3, dp_key, dp_key3;
  logic [127:0] dp_result, dp_result3, out_data, out_data3;
  logic [7:0]   sbox [256];
  logic [127:0] rk_mem [16];
  logic [127:0] pipe2 [2];
  logic [127:0] pipe3 [3];
  int checks = 0;
  int failures = 0;

  aes_round_sequencer #(.NR(NR), .RND_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rk_idx(rk_idx), .rk_data(rk_data), .dp_state(dp_state), .dp_key(dp_key), .dp_final(dp_final),
    .dp_result(dp_result), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

  aes_round_sequencer #(.NR(NR), .RND_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data),
    .rk_idx(rk_idx3), .rk_data(rk_data3), .dp_state(dp_state3), .dp_key(dp_key3), .dp_final(dp_final3),
    .dp_result(dp_result3), .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .busy(busy3));

  // ---------------- AES reference functions ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input int x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) b[rr+4*c] = a[rr+4*((c+rr)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
        b[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        b[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        b[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        b[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r ^ k;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int rn);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*rn], w[4*rn+1], w[4*rn+2], w[4*rn+3]};
  endfunction

  // State after the initial AddRoundKey and n full/final rounds.
  function automatic logic [127:0] aes_partial(input logic [127:0] pt, input logic [127:0] key, input int n);
    logic [127:0] s;
    s = pt ^ round_key(key, 0);
    for (int r = 1; r <= n; r++) s = aes_round(s, round_key(key, r), r == NR);
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- environment: key store and delay-matched datapaths ----------------
  assign rk_data  = rk_mem[rk_idx];
  assign rk_data3 = rk_mem[rk_idx3];

  always @(posedge clk) begin
    pipe2[0] <= aes_round(dp_state, dp_key, dp_final);
    pipe2[1] <= pipe2[0];
    pipe3[0] <= aes_round(dp_state3, dp_key3, dp_final3);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign dp_result  = pipe2[1];
  assign dp_result3 = pipe3[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input logic [127:0] key);
    for (int r = 0; r < 16; r++) rk_mem[r] = (r <= NR) ? round_key(key, r) : 128'h0;
  endtask

  // Presents pt until accepted; returns just after the accept edge.
  task automatic send(input logic [127:0] pt, output bit ok);
    logic rdy;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = pt;
    for (int i = 0; i < 100; i++) begin
      rdy = in_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Counts edges after the current point until out_valid is seen.
  task automatic wait_out(output int n, output bit ok);
    ok = 1'b0;
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (dp_state !== 128'h0) begin failures++; $display("FAIL reset_dp_state: got %h want 0", dp_state); end
    checks++; if (rk_idx !== 4'd0) begin failures++; $display("FAIL reset_rk_idx: got %0d want 0", rk_idx); end
    checks++; if (dp_final !== 1'b0) begin failures++; $display("FAIL reset_dp_final: got %b want 0", dp_final); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fips();
    bit ok, ok2;
    int n;
    set_key(FIPS_KEY);
    out_ready = 1'b1;
    send(FIPS_PT, ok);
    checks++; if (!ok) begin failures++; $display("FAIL fips_accept: got timeout want accept"); end
    wait_out(n, ok2);
    checks++; if (!ok2 || n != 30) begin failures++; $display("FAIL fips_latency: got %0d want 30", n); end
    checks++; if (out_data !== FIPS_CT) begin failures++; $display("FAIL fips_data: got %h want %h", out_data, FIPS_CT); end
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL fips_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_sequencing();
    bit ok;
    int rn;
    logic [127:0] key, pt;
    key = rnd128(); pt = rnd128();
    set_key(key);
    out_ready = 1'b1;
    checks++; if (rk_idx !== 4'd0) begin failures++; $display("FAIL seq_idle_idx: got %0d want 0", rk_idx); end
    send(pt, ok);
    checks++; if (!ok) begin failures++; $display("FAIL seq_accept: got timeout want accept"); end
    for (int j = 0; j < NR * 3; j++) begin
      rn = j / 3 + 1;
      checks++; if (rk_idx !== 4'(rn)) begin failures++; $display("FAIL seq_rk_idx: cycle %0d got %0d want %0d", j, rk_idx, rn); end
      checks++; if (dp_final !== (rn == NR)) begin failures++; $display("FAIL seq_dp_final: cycle %0d got %b want %b", j, dp_final, rn == NR); end
      checks++; if (dp_key !== round_key(key, rn)) begin failures++; $display("FAIL seq_dp_key: cycle %0d got %h", j, dp_key); end
      checks++; if (dp_state !== aes_partial(pt, key, rn - 1)) begin failures++; $display("FAIL seq_dp_state: cycle %0d got %h want %h", j, dp_state, aes_partial(pt, key, rn - 1)); end
      tick();
    end
    checks++; if (out_valid !== 1'b1 || rk_idx !== 4'd0 || dp_final !== 1'b0) begin failures++; $display("FAIL seq_done: got out_valid=%b rk_idx=%0d dp_final=%b want 1/0/0", out_valid, rk_idx, dp_final); end
    checks++; if (out_data !== aes_partial(pt, key, NR)) begin failures++; $display("FAIL seq_data: got %h want %h", out_data, aes_partial(pt, key, NR)); end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok, ok2;
    int n, bad;
    logic [127:0] key, pt, exp_ct;
    key = rnd128(); pt = rnd128();
    exp_ct = aes_partial(pt, key, NR);
    set_key(key);
    out_ready = 1'b0;
    send(pt, ok);
    wait_out(n, ok2);
    checks++; if (!ok || !ok2 || n != 30) begin failures++; $display("FAIL bp_latency: got %0d want 30", n); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== exp_ct || in_ready !== 1'b0 || busy !== 1'b1 || rk_idx !== 4'd0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
    checks++; if (out_data !== exp_ct) begin failures++; $display("FAIL bp_data: got %h want %h", out_data, exp_ct); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_release: got in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy); end
  endtask

  task automatic test_back_to_back();
    bit ok, ok2;
    int n, cyc, emit_at, acc_at, early;
    logic [127:0] key, pt1, pt2, c1;
    key = rnd128(); pt1 = rnd128(); pt2 = rnd128();
    set_key(key);
    out_ready = 1'b1;
    send(pt1, ok);
    in_valid = 1'b1;
    in_data  = pt2;
    cyc = 0; emit_at = -1; acc_at = -1; early = 0; c1 = '0;
    while (cyc < 100 && acc_at < 0) begin
      if (out_valid && out_ready) begin emit_at = cyc; c1 = out_data; end
      if (in_ready && in_valid) acc_at = cyc;
      if (emit_at < 0 && in_ready) early++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (!ok || emit_at < 0 || acc_at != emit_at + 1) begin failures++; $display("FAIL b2b_accept_slot: got emit=%0d accept=%0d want accept=emit+1", emit_at, acc_at); end
    checks++; if (early != 0) begin failures++; $display("FAIL b2b_in_ready_busy: got %0d ready cycles want 0", early); end
    checks++; if (c1 !== aes_partial(pt1, key, NR)) begin failures++; $display("FAIL b2b_data1: got %h want %h", c1, aes_partial(pt1, key, NR)); end
    wait_out(n, ok2);
    checks++; if (!ok2 || n != 30) begin failures++; $display("FAIL b2b_latency2: got %0d want 30", n); end
    checks++; if (out_data !== aes_partial(pt2, key, NR)) begin failures++; $display("FAIL b2b_data2: got %h want %h", out_data, aes_partial(pt2, key, NR)); end
    tick();
  endtask

  task automatic test_mid_reset();
    bit ok, ok2;
    int n, bad;
    logic [127:0] key, pt;
    key = rnd128(); pt = rnd128();
    set_key(key);
    out_ready = 1'b1;
    send(pt, ok);
    for (int i = 0; i < 40 && rk_idx !== 4'd5; i++) tick();
    checks++; if (!ok || rk_idx !== 4'd5) begin failures++; $display("FAIL mr_reach_round5: got %0d want 5", rk_idx); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mr_async: got out_valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy); end
    checks++; if (dp_state !== 128'h0 || rk_idx !== 4'd0) begin failures++; $display("FAIL mr_clear: got dp_state=%h rk_idx=%0d want 0/0", dp_state, rk_idx); end
    repeat (3) tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL mr_dropped: got %0d bad cycles want 0", bad); end
    key = rnd128(); pt = rnd128();
    set_key(key);
    send(pt, ok);
    wait_out(n, ok2);
    checks++; if (!ok || !ok2 || n != 30) begin failures++; $display("FAIL mr_fresh_latency: got %0d want 30", n); end
    checks++; if (out_data !== aes_partial(pt, key, NR)) begin failures++; $display("FAIL mr_fresh_data: got %h want %h", out_data, aes_partial(pt, key, NR)); end
    tick();
  endtask

  task automatic test_random();
    bit ok, ok2;
    int n, dly;
    logic [127:0] key, pt;
    for (int k = 0; k < 4; k++) begin
      key = rnd128(); pt = rnd128();
      dly = $urandom_range(0, 3);
      set_key(key);
      out_ready = 1'b0;
      send(pt, ok);
      wait_out(n, ok2);
      checks++; if (!ok || !ok2 || n != 30) begin failures++; $display("FAIL rand_latency: blk %0d got %0d want 30", k, n); end
      checks++; if (out_data !== aes_partial(pt, key, NR)) begin failures++; $display("FAIL rand_data: blk %0d got %h want %h", k, out_data, aes_partial(pt, key, NR)); end
      repeat (dly) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rand_release: blk %0d got %b want 1", k, in_ready); end
    end
  endtask

  task automatic test_latency3();
    int n, acc;
    logic rdy;
    logic [127:0] key, pt;
    for (int k = 0; k < 2; k++) begin
      key = (k == 0) ? FIPS_KEY : rnd128();
      pt  = (k == 0) ? FIPS_PT : rnd128();
      set_key(key);
      in_data = pt;
      in_valid3 = 1'b1;
      acc = 0;
      for (int i = 0; i < 100 && acc == 0; i++) begin
        rdy = in_ready3;
        tick();
        if (rdy) acc = 1;
      end
      in_valid3 = 1'b0;
      n = 0;
      while (n < 100 && out_valid3 !== 1'b1) begin
        tick();
        n++;
      end
      checks++; if (acc == 0 || n != 40) begin failures++; $display("FAIL lat3_latency: blk %0d got %0d want 40", k, n); end
      checks++; if (out_data3 !== aes_partial(pt, key, NR)) begin failures++; $display("FAIL lat3_data: blk %0d got %h want %h", k, out_data3, aes_partial(pt, key, NR)); end
      if (k == 0) begin
        checks++; if (out_data3 !== FIPS_CT) begin failures++; $display("FAIL lat3_fips: got %h want %h", out_data3, FIPS_CT); end
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_valid3 = 1'b0;
    out_ready = 1'b0; out_ready3 = 1'b1;
    in_data = '0;
    for (int x = 0; x < 256; x++) sbox[x] = sbox_calc(x);
    set_key(FIPS_KEY);
    #2;
    test_reset();
    test_fips();
    test_sequencing();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random();
    test_latency3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Iterative AES-128 encryption controller that time-shares one full-round datapath and one final-round datapath across all rounds of a block. It accepts a plaintext block on a valid/ready handshake and performs the initial AddRoundKey itself. It then drives the shared round datapath once per round, fetching each round key by index from an external round-key store. The finished ciphertext is presented on a valid/ready output. It sits between the block-level I/O and the two round datapath instances, whose results are muxed onto `dp_result` by `dp_final`.

## Interface
- `NR`, 10: number of rounds; round `NR` uses the final-round datapath. Legal range 2..15.
- `RND_LAT`, 2: clock edges from a stable datapath input to a valid `dp_result`. Legal range ≥1.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  plaintext valid.
- `in_ready`  out  1  sequencer can accept a block.
- `in_data`  in  128  plaintext.
- `rk_idx`  out  4  round-key index requested.
- `rk_data`  in  128  round key for `rk_idx`, combinational and same cycle.
- `dp_state`  out  128  state fed to both datapaths' `state_in`.
- `dp_key`  out  128  key fed to both datapaths' key input; equals `rk_data`.
- `dp_final`  out  1  selects the final-round result onto `dp_result`.
- `dp_result`  in  128  selected datapath `state_out`.
- `out_valid`  out  1  ciphertext valid.
- `out_ready`  in  1  consumer accepts ciphertext.
- `out_data`  out  128  ciphertext.
- `busy`  out  1  block in flight (RUN or DONE).

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- Registers:
  - `state_q` (128 bits)
  - `rnd_q` (4 bits, 1..NR)
  - `cnt_q` (counts 0..RND_LAT)
- IDLE:
  - `in_ready`=1, `rk_idx`=0.
  - On `in_valid`: `state_q`<=`in_data`^`rk_data`, `rnd_q`<=1, `cnt_q`<=0, go to RUN.
- RUN:
  - `rk_idx`=`rnd_q`, `dp_state`=`state_q`, `dp_final`=(`rnd_q`==NR).
  - `dp_state` and `dp_key` stay constant for the whole round.
  - If `cnt_q`<RND_LAT: `cnt_q`++.
  - If `cnt_q`==RND_LAT (capture cycle): `state_q`<=`dp_result` and `cnt_q`<=0.
    - If `rnd_q`==NR: go to DONE.
    - Else: `rnd_q`++.
- DONE:
  - `out_valid`=1, `out_data`=`state_q`, held stable until `out_ready`.
  - On `out_ready`: go to IDLE.
- `dp_result` is sampled only in the capture cycle and ignored otherwise.
- `out_data`=`state_q` in all states, but it is meaningful only while `out_valid`=1.
- `in_ready` is low in RUN and DONE. There is no accept/emit overlap and no bypass.
- Outside RUN: `dp_state`=`state_q`, `rk_idx`=0, `dp_final`=0.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - FSM goes to IDLE immediately.
  - `state_q`, `rnd_q`, `cnt_q` clear to 0.
  - Resulting outputs: `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0, `dp_state`=0, `rk_idx`=0, `dp_final`=0.
- Reset mid-RUN or mid-DONE: the block in flight is dropped and no `out_valid` is produced.
- Each round takes RND_LAT+1 cycles. Accept-edge to `out_valid` is NR*(RND_LAT+1) cycles; with defaults this is 30.
- Throughput is one block per NR*(RND_LAT+1)+2 cycles minimum: emit edge → IDLE → accept edge.
- `out_valid`=1 with `out_ready`=1 in the first DONE cycle: handshake completes and `in_ready`=1 in the next cycle.
- `in_valid` is ignored while `in_ready`=0. Upstream must hold `in_data` until accepted.
- `out_ready` held low indefinitely: stay in DONE with `out_data` stable and `rk_idx`=0.
- `rnd_q` never exceeds NR and never wraps.

## Test plan
- FIPS-197 C.1 vector through the real round datapaths:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, expanded-key ROM on `rk_idx`/`rk_data`, plaintext 00112233445566778899aabbccddeeff.
  - Required response: `out_data`=69c4e0d86a7b0430d8cdb78070b4c55a, with `out_valid` exactly 30 cycles after the accept edge.
- Output backpressure:
  - Stimulus: hold `out_ready`=0 for 20 cycles after `out_valid`.
  - Required response: `out_data` stable, `in_ready`=0 throughout; after `out_ready`=1 for one cycle, `in_ready`=1 in the next cycle.
- Input during a block:
  - Stimulus: assert `in_valid` continuously with a second plaintext while RUN.
  - Required response: second block accepted only in the cycle after the first handshake; both ciphertexts are correct.
- Per-round sequencing:
  - Required response: `rk_idx` steps 0,1,…,10, each value 1..10 held for 3 cycles; `dp_final`=1 only while `rk_idx`=10; `dp_state` constant within each round.
- Mid-operation reset:
  - Stimulus: pull `rst_n` low at round 5.
  - Required response: `out_valid`=0 and `in_ready`=1 immediately; after release, a fresh block completes with the correct result.
- Non-default latency:
  - Stimulus: RND_LAT=3 with a delay-matched datapath model, FIPS vector.
  - Required response: same ciphertext, latency 40 cycles.
